// File: rtl/pwm_measure.sv
// rtl/pwm_measure.sv - PWM period / high-time capture with dead-line timeout
`timescale 1ns/1ps
module pwm_measure #(
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             stuck_o,
  output logic             level_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic                     s_d_q;
  logic                     s;
  logic                     rise;
  logic                     timeout;
  logic [CNT_W-1:0]         pcnt_q, pcnt_d;
  logic [CNT_W-1:0]         hcnt_q, hcnt_d;
  logic [CNT_W-1:0]         period_q, period_d;
  logic [CNT_W-1:0]         high_q, high_d;
  logic                     valid_q, valid_d;
  logic                     stuck_q, stuck_d;
  logic                     level_q, level_d;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d_q;
  assign timeout = (pcnt_q == TIMEOUT_C);

  // Bring the asynchronous input into the clk domain and keep one cycle of history for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      s_d_q  <= s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a rise arms measurement, a timeout without a rise or a disable drops back to IDLE
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise) state_d = MEAS;
        MEAS:    if (!rise && timeout) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counter and report next-state; rise takes priority over timeout so a period of exactly TIMEOUT is reported normally
  always_comb begin
    pcnt_d   = pcnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    stuck_d  = stuck_q;
    level_d  = level_q;
    valid_d  = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            pcnt_d = ONE;
            hcnt_d = ONE;
          end
        end
        MEAS: begin
          if (rise) begin
            period_d = pcnt_q;
            high_d   = hcnt_q;
            stuck_d  = 1'b0;
            level_d  = 1'b0;
            valid_d  = 1'b1;
            pcnt_d   = ONE;
            hcnt_d   = ONE;
          end else if (timeout) begin
            period_d = '0;
            high_d   = '0;
            stuck_d  = 1'b1;
            level_d  = s;
            valid_d  = 1'b1;
          end else begin
            // s can only be high here while still in the first high phase: any return to high after a fall is a rise
            pcnt_d = (pcnt_q == CNT_MAX) ? pcnt_q : pcnt_q + ONE;
            if (s) begin
              hcnt_d = (hcnt_q == CNT_MAX) ? hcnt_q : hcnt_q + ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Counter and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q   <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
      level_q  <= level_d;
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign stuck_o  = stuck_q;
  assign level_o  = level_q;

endmodule

// File: tb/tb_pwm_measure.sv
// tb/tb_pwm_measure.sv - scoreboard bench for pwm_measure against a timestamp-based edge model
`timescale 1ns/1ps
module tb_pwm_measure;

  localparam int SYNC = 2;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        pwm_i;
  logic [31:0] period_o;
  logic [31:0] high_o;
  logic        valid_o;
  logic        stuck_o;
  logic        level_o;

  pwm_measure #(
    .CNT_W(32),
    .SYNC_STAGES(SYNC),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .pwm_i(pwm_i),
    .period_o(period_o),
    .high_o(high_o),
    .valid_o(valid_o),
    .stuck_o(stuck_o),
    .level_o(level_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int e;
    int period;
    int high;
    bit stuck;
    bit level;
  } rep_t;

  rep_t exp_q[$];
  rep_t mx;
  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;

  // reference model: timestamps of rising / falling edges of the synchronized line
  bit   lv[int];
  int   rst_last = 0;
  bit   meas = 0;
  bit   fell = 0;
  int   t_rise = 0;
  int   t_fall = 0;

  function automatic bit lvl(input int j);
    if (j <= rst_last) return 1'b0;
    if (!lv.exists(j)) return 1'b0;
    return lv[j];
  endfunction

  // decision at clock edge e sees the input level sampled SYNC edges earlier
  task automatic model_step(input int e, input bit p, input bit en_v, input bit r_v);
    bit s_now, s_prev, rise, fall;
    rep_t r;
    if (!r_v) begin
      rst_last = e;
      meas = 0;
      return;
    end
    lv[e] = p;
    s_now  = lvl(e - SYNC);
    s_prev = lvl(e - SYNC - 1);
    rise = s_now & ~s_prev;
    fall = ~s_now & s_prev;
    if (!en_v) begin
      meas = 0;
      return;
    end
    if (!meas) begin
      if (rise) begin
        meas = 1; t_rise = e; fell = 0;
      end
      return;
    end
    if (rise) begin
      r.e = e; r.period = e - t_rise;
      r.high = fell ? (t_fall - t_rise) : (e - t_rise);
      r.stuck = 0; r.level = 0;
      exp_q.push_back(r);
      t_rise = e; fell = 0;
      return;
    end
    if (fall && !fell) begin
      fell = 1; t_fall = e;
    end
    if (e - t_rise == TMO) begin
      r.e = e; r.period = 0; r.high = 0; r.stuck = 1; r.level = s_now;
      exp_q.push_back(r);
      meas = 0;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      model_step(edge_n, pwm_i, en, rst_n);
    end
  end

  // monitor: every report the DUT presents is popped and compared, late/missing ones are flagged
  initial begin
    forever begin
      @(negedge clk);
      if (valid_o === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_report edge=%0d got period=%0d high=%0d stuck=%0d level=%0d, required no report",
                   edge_n, period_o, high_o, stuck_o, level_o);
        end else begin
          mx = exp_q.pop_front();
          if (mx.e != edge_n || period_o !== 32'(mx.period) || high_o !== 32'(mx.high) ||
              stuck_o !== mx.stuck || level_o !== mx.level) begin
            fails++;
            $display("FAIL report edge=%0d got period=%0d high=%0d stuck=%0d level=%0d, required edge=%0d period=%0d high=%0d stuck=%0d level=%0d",
                     edge_n, period_o, high_o, stuck_o, level_o, mx.e, mx.period, mx.high, mx.stuck, mx.level);
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].e <= edge_n) begin
        tests++;
        fails++;
        mx = exp_q.pop_front();
        $display("FAIL missing_report edge=%0d got valid=0, required period=%0d high=%0d stuck=%0d level=%0d",
                 edge_n, mx.period, mx.high, mx.stuck, mx.level);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endtask

  // behavioural PWM generator: duty and period latched at each period boundary
  int g_cnt = 0, g_f = 1, g_w = 0, g_f_nx = 1, g_w_nx = 0;

  task automatic start_gen(input int f, input int w);
    g_f = f; g_w = w; g_f_nx = f; g_w_nx = w; g_cnt = 0;
  endtask

  task automatic gen(input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_i = (g_cnt < g_w);
      g_cnt++;
      if (g_cnt > g_f) begin
        g_cnt = 0; g_w = g_w_nx; g_f = g_f_nx;
      end
    end
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) begin
      @(negedge clk);
      pwm_i = v;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period_o, 32'd0);
    chk({tag, "_high"},   high_o,   32'd0);
    chk({tag, "_valid"},  {31'd0, valid_o}, 32'd0);
    chk({tag, "_stuck"},  {31'd0, stuck_o}, 32'd0);
    chk({tag, "_level"},  {31'd0, level_o}, 32'd0);
  endtask

  logic [31:0] h_p, h_h;
  logic        h_s, h_l;

  initial begin
    int f, w;
    rst_n = 1'b0; en = 1'b0; pwm_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1; en = 1'b1;

    start_gen(99, 25);  gen(600);
    g_w_nx = 80;        gen(600);
    hold(1'b1, 1200);
    start_gen(9, 3);    gen(60);
    hold(1'b0, 1200);
    start_gen(9, 3);    gen(60);
    start_gen(TMO - 1, 7); gen(3 * TMO + 10);
    start_gen(1, 1);    gen(20);

    start_gen(29, 10);  gen(75);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    rst_n = 1'b1;
    gen(100);

    gen(45);
    h_p = period_o; h_h = high_o; h_s = stuck_o; h_l = level_o;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      gen(1);
      chk("endrop_period", period_o, h_p);
      chk("endrop_high",   high_o,   h_h);
      chk("endrop_stuck",  {31'd0, stuck_o}, {31'd0, h_s});
      chk("endrop_level",  {31'd0, level_o}, {31'd0, h_l});
    end
    en = 1'b1;
    gen(100);

    for (int k = 0; k < 25; k++) begin
      f = int'($urandom_range(1, 40));
      w = int'($urandom_range(0, f + 2));
      start_gen(f, w);
      gen(int'($urandom_range(50, 300)));
      case ($urandom_range(0, 3))
        0: begin @(negedge clk); en = 1'b0; gen(int'($urandom_range(1, 8))); en = 1'b1; end
        1: begin @(negedge clk); rst_n = 1'b0; gen(int'($urandom_range(1, 3))); rst_n = 1'b1; end
        default: ;
      endcase
    end

    hold(1'b0, 20);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_reports: got %0d outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_measure.md
# pwm_measure

Capture-side companion of the PWM generator. Samples an external or looped-back PWM input, measures period and high time in `clk` cycles, and reports them as 32-bit values in the same units as the generator's `fre_set`/`wav_set` path. It lets the motor/fan control software close the loop on tach-style PWM feedback and self-test the generator. A timeout detects a dead input line and reports its static level.

## Interface
- `CNT_W`, 32: width of the counters and result outputs.
- `SYNC_STAGES`, 2: input synchronizer depth, minimum 2.
- `TIMEOUT`, 50_000_000: cycles without a rising edge before the input is declared stuck. Must be ≥ 2 and < 2^CNT_W − 1.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset; synchronous, active-low; clock `clk`.
- `en` in 1: measurement enable.
- `pwm_i` in 1: asynchronous PWM input.
- `period_o` out CNT_W: last measured period, in cycles between rising edges.
- `high_o` out CNT_W: last measured high time, in cycles.
- `valid_o` out 1: one-cycle strobe; `period_o`, `high_o`, `stuck_o` and `level_o` updated this cycle.
- `stuck_o` out 1: set when the last report was a timeout.
- `level_o` out 1: synchronized input level captured at timeout.

## Operation
- Synchronizer: `pwm_i` passes through `SYNC_STAGES` flops to give `s`. `s_d` is `s` delayed by one cycle. `rise = s & ~s_d`.
- `pcnt` and `hcnt` are CNT_W wide and saturate at all-ones; they never wrap.
- FSM states: IDLE, MEAS.
  - IDLE: counters are held. On `rise` with `en=1`, go to MEAS and set `pcnt=1`, `hcnt=1`. No report is produced, because the first period is partial.
  - MEAS, each cycle without `rise`: `pcnt` increments. `hcnt` increments only while `s=1` and no falling edge has been seen since the last rise.
  - MEAS with `rise`: register `period_o=pcnt`, `high_o=hcnt`, `stuck_o=0`, `level_o=0`. Pulse `valid_o`. Reload `pcnt=1`, `hcnt=1`. Stay in MEAS.
  - MEAS with `pcnt==TIMEOUT` and no `rise`: register `period_o=0`, `high_o=0`, `stuck_o=1`, `level_o=s`. Pulse `valid_o`. Go to IDLE.
- `rise` and timeout in the same cycle: `rise` wins and a normal report is produced.
- `en` deasserted: go to IDLE next cycle. Outputs hold their last values. `valid_o` stays 0 while `en=0` and is 0 in the cycle `en` falls.
- While IDLE, a stuck line produces no further reports. `stuck_o` stays set until the next normal report.
- There is no glitch filtering. A 1-cycle pulse on `s` is measured as `high=1`.
- Generator compatibility: generator settings `fre_set=F`, `wav_set=W` give `period_o=F+1` and `high_o=min(W,F+1)`. With `W=0` the line is constantly low and times out with `level_o=0`. With `W>F` it is constantly high and times out with `level_o=1`.

## Timing
- Reset values: `period_o=0`, `high_o=0`, `valid_o=0`, `stuck_o=0`, `level_o=0`. The FSM is in IDLE, the synchronizer flops are 0, and the counters are 0.
- Reset mid-measurement discards the partial measurement. The first report after reset requires two rising edges.
- Latency: if `pwm_i` is first sampled high at clock edge k, `rise` is true in the cycle after edge k+SYNC_STAGES−1. `valid_o` and the new values are visible after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 edges from the sampling edge.
- Timeout report: `valid_o` is asserted the cycle after `pcnt` reaches `TIMEOUT`, which is `TIMEOUT` cycles after the last `rise`.
- Outputs are fully registered. `valid_o` is never high on two consecutive cycles except for back-to-back 1-cycle periods, which are impossible because a period is at least 2 cycles.
- Minimum measurable period is 2 cycles; minimum high time is 1 cycle.

## Test plan
- Loop-back from a generator with `fre_set=99`, `wav_set=25`, `en=1`:
  - the first rise after enable gives no report;
  - each subsequent rise gives `valid_o` with `period_o=100`, `high_o=25`, `stuck_o=0`.
- Duty change on the fly from 25 to 80: exactly one report shows 25 or 80, never an intermediate value. Every later report shows `high_o=80` and `period_o=100`.
- Stuck line, with `TIMEOUT=1000`:
  - hold `pwm_i=1` after a valid period: after 1000 cycles `valid_o` pulses with `period_o=0`, `high_o=0`, `stuck_o=1`, `level_o=1`, and the FSM is in IDLE;
  - repeat the same sequence with the line held low: `level_o=0`.
- Recovery from stuck: restart a 10-cycle / 3-high PWM. The first rise gives no report. The second gives `period_o=10`, `high_o=3`, `stuck_o=0`.
- Boundary: drive `pwm_i` so that a rise arrives exactly when `pcnt==TIMEOUT`. Require a normal report with `period_o=TIMEOUT` and no stuck report. Drive a 2-cycle period with 1-cycle high and require `period_o=2`, `high_o=1`.
- Reset or `en` drop mid-period:
  - assert `rst_n=0` for 1 cycle midway: all outputs read 0 the next cycle, and the next report needs two rises;
  - drop `en` for 5 cycles instead: outputs hold, no `valid_o`, and re-sync follows the same rule.
